// File: rtl/dff_bank_arbiter_if.sv
// Request/grant bus between four requesters and the shared register bank.
// Each flat vector carries one slice per requester, with requester 0 in the low slice.
interface dff_bank_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [3:0]         req;
  logic [3:0]         we;
  logic [7:0]         addr;
  logic [4*WIDTH-1:0] wdata;
  logic [3:0]         gnt;
  logic [1:0]         gnt_id;
  logic [WIDTH-1:0]   rdata;
  logic               rvalid;

  modport master (
    output req, we, addr, wdata,
    input  gnt, gnt_id, rdata, rvalid
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, gnt_id, rdata, rvalid
  );
endinterface

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter that gives four requesters one read or write each
// into a shared DEPTH x WIDTH flip-flop register bank.
module dff_bank_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  dff_bank_arbiter_if.slave   bus
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e           state_q, state_d;
  logic [1:0]       lastPtr_q, lastPtr_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       gntId_q, gntId_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic [WIDTH-1:0] bank_q [DEPTH];

  logic [1:0]       addrArr [4];
  logic [WIDTH-1:0] wdataArr [4];
  logic             selWe;
  logic [1:0]       selAddr;
  logic [WIDTH-1:0] selWdata;
  logic             bankWrite;
  logic             found;
  logic [1:0]       cand;
  logic [1:0]       winner;

  // Split the flat buses and pick out the fields of the requester holding the grant.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      addrArr[i]  = bus.addr[2*i +: 2];
      wdataArr[i] = bus.wdata[WIDTH*i +: WIDTH];
    end
    selWe    = bus.we[gntId_q];
    selAddr  = addrArr[gntId_q];
    selWdata = wdataArr[gntId_q];
  end

  always_comb begin
    state_d   = state_q;
    lastPtr_d = lastPtr_q;
    gnt_d     = '0;
    gntId_d   = gntId_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    bankWrite = 1'b0;
    found     = 1'b0;
    cand      = '0;
    winner    = lastPtr_q;
    case (state_q)
      IDLE: begin
        // Search starts just past the last winner; k=4 wraps back to it.
        for (int k = 1; k <= 4; k++) begin
          cand = lastPtr_q + 2'(k);
          if (!found && bus.req[cand]) begin
            found  = 1'b1;
            winner = cand;
          end
        end
        if (found) begin
          gnt_d     = 4'b0001 << winner;
          gntId_d   = winner;
          lastPtr_d = winner;
          state_d   = GRANT;
        end
      end
      GRANT: begin
        if (selWe) begin
          bankWrite = 1'b1;
        end else begin
          rdata_d  = bank_q[selAddr];
          rvalid_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      lastPtr_q <= 2'd3;
      gnt_q     <= '0;
      gntId_q   <= 2'd3;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      lastPtr_q <= lastPtr_d;
      gnt_q     <= gnt_d;
      gntId_q   <= gntId_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank_q[i] <= '0;
      end
    end else if (bankWrite) begin
      bank_q[selAddr] <= selWdata;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.gnt_id = gntId_q;
  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;

endmodule
